// File: rtl/pwm_pkg.sv
// Shared mode encodings, controller state type and the mode-to-state mapping
// used by the pwm_gen pulse generator.
package pwm_pkg;

    localparam logic [1:0] PWM_MODE_LOW   = 2'd0;
    localparam logic [1:0] PWM_MODE_HIGH  = 2'd1;
    localparam logic [1:0] PWM_MODE_PWM   = 2'd2;
    localparam logic [1:0] PWM_MODE_PULSE = 2'd3;

    typedef enum logic [1:0] {
        ST_LOW   = 2'd0,
        ST_HIGH  = 2'd1,
        ST_PWM   = 2'd2,
        ST_PULSE = 2'd3
    } pwm_state_t;

    // A zero-length pulse never enters PULSE; it lands directly in LOW.
    function automatic pwm_state_t mode_to_state(input logic [1:0] mode, input logic duty_zero);
        pwm_state_t st;
        case (mode)
            PWM_MODE_LOW:   st = ST_LOW;
            PWM_MODE_HIGH:  st = ST_HIGH;
            PWM_MODE_PWM:   st = ST_PWM;
            PWM_MODE_PULSE: st = duty_zero ? ST_LOW : ST_PULSE;
            default:        st = ST_LOW;
        endcase
        return st;
    endfunction

endpackage

// File: rtl/pwm_gen_if.sv
// Configuration and status bundle between a register master and pwm_gen.
interface pwm_gen_if #(
    parameter int WIDTH = 16
);
    import pwm_pkg::*;

    logic             cfg_we;
    logic [1:0]       cfg_mode;
    logic [WIDTH-1:0] cfg_period;
    logic [WIDTH-1:0] cfg_duty;
    logic             pwm_out;
    logic             period_start;
    logic             busy;

    modport master (
        output cfg_we, cfg_mode, cfg_period, cfg_duty,
        input  pwm_out, period_start, busy
    );

    modport slave (
        input  cfg_we, cfg_mode, cfg_period, cfg_duty,
        output pwm_out, period_start, busy
    );

endinterface

// File: rtl/pwm_prescaler.sv
// Free-running clock divider: tick is high for one clk out of every PRESCALE;
// clr restarts the count so a new period or pulse starts on a full tick.
module pwm_prescaler #(
    parameter int PRESCALE = 50
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    output logic tick
);
    import pwm_pkg::*;

    localparam int            CW   = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [CW-1:0] LAST = CW'(PRESCALE - 1);

    logic [CW-1:0] div_cnt_r;

    assign tick = (div_cnt_r == LAST);

    // Divider count register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_cnt_r <= '0;
        end else if (clr || tick) begin
            div_cnt_r <= '0;
        end else begin
            div_cnt_r <= div_cnt_r + CW'(1);
        end
    end

endmodule

// File: rtl/pwm_gen.sv
// PWM / one-shot generator: configuration is staged in pending registers and
// applied only at safe points so the output never shows a runt cycle.
module pwm_gen
    import pwm_pkg::*;
#(
    parameter int WIDTH    = 16,
    parameter int PRESCALE = 50
) (
    input  logic      clk,
    input  logic      rst,
    pwm_gen_if.slave  bus
);

    logic             pend_r;
    logic [1:0]       pmode_r;
    logic [WIDTH-1:0] pperiod_r;
    logic [WIDTH-1:0] pduty_r;

    pwm_state_t       state_r;
    logic [WIDTH-1:0] period_r;
    logic [WIDTH-1:0] duty_r;
    logic [WIDTH-1:0] cnt_r;

    logic             pwm_out_r;
    logic             period_start_r;
    logic             busy_r;

    logic             tick_s;
    logic             clr_s;
    logic             wrap_s;
    logic             pulse_end_s;
    logic             apply_s;
    logic             start_evt_s;
    logic             pend_s;
    pwm_state_t       state_s;
    logic [WIDTH-1:0] period_s;
    logic [WIDTH-1:0] duty_s;
    logic [WIDTH-1:0] cnt_s;
    logic             pwm_out_s;
    logic             period_start_s;
    logic             busy_s;

    pwm_prescaler #(
        .PRESCALE (PRESCALE)
    ) u_prescaler (
        .clk  (clk),
        .rst  (rst),
        .clr  (clr_s),
        .tick (tick_s)
    );

    // Pending configuration capture; last write before apply wins.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pmode_r   <= PWM_MODE_LOW;
            pperiod_r <= '0;
            pduty_r   <= '0;
        end else if (bus.cfg_we) begin
            pmode_r   <= bus.cfg_mode;
            pperiod_r <= bus.cfg_period;
            pduty_r   <= bus.cfg_duty;
        end else begin
            pmode_r   <= pmode_r;
            pperiod_r <= pperiod_r;
            pduty_r   <= pduty_r;
        end
    end

    // Controller state, active configuration and tick counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r  <= ST_LOW;
            pend_r   <= 1'b0;
            period_r <= '0;
            duty_r   <= '0;
            cnt_r    <= '0;
        end else begin
            state_r  <= state_s;
            pend_r   <= pend_s;
            period_r <= period_s;
            duty_r   <= duty_s;
            cnt_r    <= cnt_s;
        end
    end

    // Next-state logic: apply points, counter advance, wrap and pulse end.
    always_comb begin
        // A zero period never wraps on its own, so it is applied like a level mode.
        wrap_s      = (state_r == ST_PWM) && tick_s &&
                      ((period_r == '0) || (cnt_r == period_r - WIDTH'(1)));
        pulse_end_s = (state_r == ST_PULSE) && tick_s && (cnt_r == duty_r - WIDTH'(1));

        case (state_r)
            ST_LOW, ST_HIGH: apply_s = pend_r;
            ST_PWM:          apply_s = pend_r && (wrap_s || (period_r == '0));
            ST_PULSE:        apply_s = 1'b0;
            default:         apply_s = 1'b0;
        endcase

        state_s     = state_r;
        period_s    = period_r;
        duty_s      = duty_r;
        cnt_s       = cnt_r;
        start_evt_s = 1'b0;

        if (apply_s) begin
            state_s     = mode_to_state(pmode_r, pduty_r == '0);
            period_s    = pperiod_r;
            duty_s      = pduty_r;
            cnt_s       = '0;
            start_evt_s = (state_s == ST_PWM);
        end else if (state_r == ST_PWM) begin
            if (wrap_s) begin
                cnt_s       = '0;
                start_evt_s = 1'b1;
            end else if (tick_s) begin
                cnt_s = cnt_r + WIDTH'(1);
            end else begin
                cnt_s = cnt_r;
            end
        end else if (state_r == ST_PULSE) begin
            // Pulse end drops to LOW; a queued write is applied from LOW next cycle.
            if (pulse_end_s) begin
                state_s = ST_LOW;
                cnt_s   = '0;
            end else if (tick_s) begin
                cnt_s = cnt_r + WIDTH'(1);
            end else begin
                cnt_s = cnt_r;
            end
        end else begin
            cnt_s = '0;
        end

        if (bus.cfg_we) begin
            pend_s = 1'b1;
        end else if (apply_s) begin
            pend_s = 1'b0;
        end else begin
            pend_s = pend_r;
        end

        clr_s = apply_s && ((state_s == ST_PWM) || (state_s == ST_PULSE));
    end

    // Output decode from next-state values so the registered pins line up with state.
    always_comb begin
        case (state_s)
            ST_HIGH, ST_PULSE: pwm_out_s = 1'b1;
            ST_PWM:            pwm_out_s = (period_s != '0) && (cnt_s < duty_s);
            ST_LOW:            pwm_out_s = 1'b0;
            default:           pwm_out_s = 1'b0;
        endcase
        period_start_s = start_evt_s && (period_s != '0);
        busy_s         = pend_s || (state_s == ST_PULSE);
    end

    // Output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pwm_out_r      <= 1'b0;
            period_start_r <= 1'b0;
            busy_r         <= 1'b0;
        end else begin
            pwm_out_r      <= pwm_out_s;
            period_start_r <= period_start_s;
            busy_r         <= busy_s;
        end
    end

    assign bus.pwm_out      = pwm_out_r;
    assign bus.period_start = period_start_r;
    assign bus.busy         = busy_r;

endmodule

// File: tb/tb_pwm_gen.sv
// Scoreboard bench for pwm_gen: expected edges of pwm_out/busy, period_start
// cycles and level snapshots are queued by clk-edge index and checked by a monitor.
`timescale 1ns/1ps
module tb_pwm_gen;

    localparam int WIDTH    = 16;
    localparam int PRESCALE = 4;

    typedef struct { int cyc; logic lvl; } ev_t;
    typedef struct { int cyc; logic out; logic busy; logic ps; } lvl_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   errors = 0;
    int   checks = 0;
    bit   done = 1'b0;
    bit   mon_done = 1'b0;

    ev_t  q_out[$];
    ev_t  q_busy[$];
    int   q_ps[$];
    lvl_t q_lvl[$];

    pwm_gen_if #(.WIDTH(WIDTH)) bus ();

    pwm_gen #(.WIDTH(WIDTH), .PRESCALE(PRESCALE)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic exp_out(input int c, input logic l);
        ev_t e; e.cyc = c; e.lvl = l; q_out.push_back(e);
    endtask
    task automatic exp_busy(input int c, input logic l);
        ev_t e; e.cyc = c; e.lvl = l; q_busy.push_back(e);
    endtask
    task automatic exp_ps(input int c);
        q_ps.push_back(c);
    endtask
    task automatic exp_lvl(input int c, input logic o, input logic b, input logic p);
        lvl_t l; l.cyc = c; l.out = o; l.busy = b; l.ps = p; q_lvl.push_back(l);
    endtask
    task automatic wait_until(input int t);
        while (cyc < t) @(negedge clk);
    endtask
    // Called at a negedge; the write is sampled on the following rising edge.
    task automatic cfg_write(input logic [1:0] m, input logic [15:0] p, input logic [15:0] d);
        bus.cfg_mode = m; bus.cfg_period = p; bus.cfg_duty = d; bus.cfg_we = 1'b1;
        @(negedge clk);
        bus.cfg_we = 1'b0;
    endtask

    // Monitor: compares every observed output event against the scoreboard.
    logic prev_out = 1'b0;
    logic prev_busy = 1'b0;
    initial forever begin
        ev_t  e;
        lvl_t l;
        int   c;
        @(negedge clk);
        if (bus.pwm_out !== prev_out) begin
            checks++;
            if (q_out.size() == 0) begin
                errors++;
                $display("FAIL out_edge: got unexpected edge to %b at cycle %0d, required none", bus.pwm_out, cyc);
            end else begin
                e = q_out.pop_front();
                if (e.cyc != cyc || e.lvl !== bus.pwm_out) begin
                    errors++;
                    $display("FAIL out_edge: got %b at cycle %0d, required %b at cycle %0d", bus.pwm_out, cyc, e.lvl, e.cyc);
                end
            end
        end
        while (q_out.size() > 0 && q_out[0].cyc < cyc) begin
            e = q_out.pop_front(); checks++; errors++;
            $display("FAIL out_edge: got no edge, required edge to %b at cycle %0d", e.lvl, e.cyc);
        end
        if (bus.busy !== prev_busy) begin
            checks++;
            if (q_busy.size() == 0) begin
                errors++;
                $display("FAIL busy_edge: got unexpected edge to %b at cycle %0d, required none", bus.busy, cyc);
            end else begin
                e = q_busy.pop_front();
                if (e.cyc != cyc || e.lvl !== bus.busy) begin
                    errors++;
                    $display("FAIL busy_edge: got %b at cycle %0d, required %b at cycle %0d", bus.busy, cyc, e.lvl, e.cyc);
                end
            end
        end
        while (q_busy.size() > 0 && q_busy[0].cyc < cyc) begin
            e = q_busy.pop_front(); checks++; errors++;
            $display("FAIL busy_edge: got no edge, required edge to %b at cycle %0d", e.lvl, e.cyc);
        end
        if (bus.period_start !== 1'b0) begin
            checks++;
            if (q_ps.size() == 0) begin
                errors++;
                $display("FAIL period_start: got strobe (%b) at cycle %0d, required none", bus.period_start, cyc);
            end else begin
                c = q_ps.pop_front();
                if (c != cyc) begin
                    errors++;
                    $display("FAIL period_start: got strobe at cycle %0d, required at cycle %0d", cyc, c);
                end
            end
        end
        while (q_ps.size() > 0 && q_ps[0] < cyc) begin
            c = q_ps.pop_front(); checks++; errors++;
            $display("FAIL period_start: got no strobe, required at cycle %0d", c);
        end
        while (q_lvl.size() > 0 && q_lvl[0].cyc <= cyc) begin
            l = q_lvl.pop_front(); checks++;
            if (l.cyc != cyc || bus.pwm_out !== l.out || bus.busy !== l.busy || bus.period_start !== l.ps) begin
                errors++;
                $display("FAIL level: cycle %0d got out=%b busy=%b ps=%b, required out=%b busy=%b ps=%b at cycle %0d",
                         cyc, bus.pwm_out, bus.busy, bus.period_start, l.out, l.busy, l.ps, l.cyc);
            end
        end
        if (done && !mon_done) begin
            checks++;
            if (q_out.size() + q_busy.size() + q_ps.size() + q_lvl.size() != 0) begin
                errors++;
                $display("FAIL drain: got %0d unmatched expectations, required 0",
                         q_out.size() + q_busy.size() + q_ps.size() + q_lvl.size());
            end
            mon_done = 1'b1;
        end
        prev_out  = bus.pwm_out;
        prev_busy = bus.busy;
    end

    // Stimulus: directed scenarios with hand-computed event cycles (PRESCALE=4).
    initial begin
        int k, e, c, t;
        bus.cfg_we = 1'b0; bus.cfg_mode = 2'd0; bus.cfg_period = 16'd0; bus.cfg_duty = 16'd0;
        repeat (5) @(negedge clk);
        rst = 1'b0;

        // Reset state and 1000 idle cycles.
        t = cyc;
        exp_lvl(t + 1, 1'b0, 1'b0, 1'b0);
        exp_lvl(t + 1000, 1'b0, 1'b0, 1'b0);
        wait_until(t + 1000);

        // Level high then back to low.
        k = cyc + 1;
        exp_busy(k, 1'b1); exp_busy(k + 1, 1'b0); exp_out(k + 1, 1'b1);
        exp_lvl(k + 500, 1'b1, 1'b0, 1'b0); exp_lvl(k + 1000, 1'b1, 1'b0, 1'b0);
        cfg_write(2'd1, 16'd0, 16'd0);
        wait_until(k + 1000);
        k = cyc + 1;
        exp_busy(k, 1'b1); exp_busy(k + 1, 1'b0); exp_out(k + 1, 1'b0);
        exp_lvl(k + 2, 1'b0, 1'b0, 1'b0);
        cfg_write(2'd0, 16'd0, 16'd0);
        wait_until(k + 5);

        // PWM 10/3, rewrite to 10/7 at counter 5 of the third period, then stop.
        k = cyc + 1; e = k + 1;
        exp_busy(k, 1'b1); exp_busy(e, 1'b0);
        exp_busy(e + 100, 1'b1); exp_busy(e + 120, 1'b0);
        exp_busy(e + 180, 1'b1); exp_busy(e + 200, 1'b0);
        for (int i = 0; i < 3; i++) begin
            exp_out(e + 40 * i, 1'b1); exp_out(e + 40 * i + 12, 1'b0); exp_ps(e + 40 * i);
        end
        for (int i = 0; i < 2; i++) begin
            exp_out(e + 120 + 40 * i, 1'b1); exp_out(e + 148 + 40 * i, 1'b0); exp_ps(e + 120 + 40 * i);
        end
        exp_lvl(e + 110, 1'b0, 1'b1, 1'b0);
        exp_lvl(e + 200, 1'b0, 1'b0, 1'b0);
        cfg_write(2'd2, 16'd10, 16'd3);
        wait_until(e + 99);
        cfg_write(2'd2, 16'd10, 16'd7);
        wait_until(e + 179);
        cfg_write(2'd0, 16'd0, 16'd0);
        wait_until(e + 205);

        // One-shot of 25 ticks, then 1000 quiet cycles.
        k = cyc + 1; e = k + 1;
        exp_busy(k, 1'b1); exp_busy(e + 100, 1'b0);
        exp_out(e, 1'b1); exp_out(e + 100, 1'b0);
        exp_lvl(e + 50, 1'b1, 1'b1, 1'b0); exp_lvl(e + 1100, 1'b0, 1'b0, 1'b0);
        cfg_write(2'd3, 16'd0, 16'd25);
        wait_until(e + 1100);

        // Retrigger during a pulse: second pulse after a single low cycle.
        k = cyc + 1; e = k + 1;
        exp_busy(k, 1'b1); exp_busy(e + 201, 1'b0);
        exp_out(e, 1'b1); exp_out(e + 100, 1'b0); exp_out(e + 101, 1'b1); exp_out(e + 201, 1'b0);
        exp_lvl(e + 100, 1'b0, 1'b1, 1'b0);
        cfg_write(2'd3, 16'd0, 16'd25);
        wait_until(e + 49);
        cfg_write(2'd3, 16'd0, 16'd25);
        wait_until(e + 210);

        // duty=0: output stays low, period_start still every 40 clk.
        k = cyc + 1; e = k + 1;
        exp_busy(k, 1'b1); exp_busy(e, 1'b0); exp_busy(e + 100, 1'b1); exp_busy(e + 120, 1'b0);
        exp_ps(e); exp_ps(e + 40); exp_ps(e + 80);
        exp_lvl(e + 20, 1'b0, 1'b0, 1'b0);
        cfg_write(2'd2, 16'd10, 16'd0);
        wait_until(e + 99);
        cfg_write(2'd0, 16'd0, 16'd0);
        wait_until(e + 125);

        // duty>=period: constant high.
        k = cyc + 1; e = k + 1;
        exp_busy(k, 1'b1); exp_busy(e, 1'b0); exp_busy(e + 100, 1'b1); exp_busy(e + 120, 1'b0);
        exp_out(e, 1'b1); exp_out(e + 120, 1'b0);
        exp_ps(e); exp_ps(e + 40); exp_ps(e + 80);
        exp_lvl(e + 60, 1'b1, 1'b0, 1'b0);
        cfg_write(2'd2, 16'd10, 16'd12);
        wait_until(e + 99);
        cfg_write(2'd0, 16'd0, 16'd0);
        wait_until(e + 125);

        // period=0: low, no period_start, next write applies immediately.
        k = cyc + 1; e = k + 1;
        exp_busy(k, 1'b1); exp_busy(e, 1'b0);
        exp_lvl(e + 100, 1'b0, 1'b0, 1'b0);
        cfg_write(2'd2, 16'd0, 16'd5);
        wait_until(e + 199);
        k = cyc + 1;
        exp_busy(k, 1'b1); exp_busy(k + 1, 1'b0);
        cfg_write(2'd0, 16'd0, 16'd0);
        wait_until(k + 5);

        // Asynchronous reset while high: output drops before the next clk edge.
        k = cyc + 1;
        exp_busy(k, 1'b1); exp_busy(k + 1, 1'b0); exp_out(k + 1, 1'b1);
        cfg_write(2'd1, 16'd0, 16'd0);
        wait_until(k + 20);
        @(posedge clk);
        #1;
        c = cyc;
        exp_out(c, 1'b0);
        exp_lvl(c, 1'b0, 1'b0, 1'b0);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        t = cyc + 100;
        exp_lvl(t, 1'b0, 1'b0, 1'b0);
        wait_until(t + 2);

        done = 1'b1;
        for (int i = 0; i < 10 && !mon_done; i++) @(negedge clk);
        if (!mon_done) begin
            $display("FAIL monitor_timeout: got no drain check, required one within 10 cycles");
            $fatal(1, "monitor did not complete");
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/pwm_gen.md
# pwm_gen

Programmable PWM / one-shot pulse generator driving a single digital output line: motor-driver enable, servo control or indicator. A register-interface master writes mode, period and duty. The block emits a glitch-free waveform whose high time and period are exact multiples of a prescaled tick. Configuration changes in PWM mode take effect only on period boundaries, so no truncated or runt cycles appear on the pin.

## Interface
- `WIDTH`, 16: width of period, duty and tick counter.
- `PRESCALE`, 50: clk cycles per tick, ≥1; with a 50 MHz clock, 1 tick = 1 µs.
- `clk`  in  1  system clock, all logic on rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `cfg_we`  in  1  one-cycle write strobe; samples `cfg_mode`, `cfg_period`, `cfg_duty`.
- `cfg_mode`  in  2  0 = level low, 1 = level high, 2 = PWM, 3 = one-shot pulse.
- `cfg_period`  in  WIDTH  PWM period in ticks.
- `cfg_duty`  in  WIDTH  high time in ticks (PWM and one-shot).
- `pwm_out`  out  1  registered output line.
- `period_start`  out  1  one-cycle strobe on the edge where a PWM period begins.
- `busy`  out  1  high while a one-shot is running or a write is pending.

## Operation
- Reset: state LOW, `pwm_out`=0, `period_start`=0, `busy`=0, pending flag clear, counters 0.
- Write path: `cfg_we` loads pending registers and sets the pending flag. A second write before apply overwrites the pending registers (last write wins).
- States: LOW, HIGH, PWM, PULSE.
- Apply point:
  - In LOW or HIGH: the next cycle.
  - In PWM: the cycle where the tick counter wraps (end of period).
  - In PULSE: the cycle the pulse ends.
- Apply copies pending registers to active registers, clears the pending flag, and enters the state given by mode.
- Entering PWM or PULSE zeroes the prescaler and tick counter, so the first period or pulse is full length.
- Prescaler: counts 0..PRESCALE-1 and emits `tick` when at PRESCALE-1. The tick counter advances on `tick` only.
- PWM: tick counter runs 0..period-1 and wraps. `pwm_out`=1 while counter < duty.
  - `duty` ≥ `period`: constant high.
  - `duty`=0: constant low.
  - `period`=0: treated as level low and raises no `period_start`.
- PULSE: `pwm_out`=1 for `duty` ticks, then state goes to LOW with `pwm_out`=0. `duty`=0 produces no pulse and goes straight to LOW.
- `busy` = pending flag OR (state == PULSE).
- Write during PULSE: held pending and applied at pulse end. Mode 3 pending retriggers a fresh pulse with no low gap beyond the 1-cycle apply.

## Timing
- `cfg_we` sampled at edge k.
  - Level modes: `pwm_out` takes the new value at edge k+1.
  - Entry to PWM or PULSE: `pwm_out` rises at edge k+1 if duty > 0.
- PWM steady state:
  - High time = duty·PRESCALE clk cycles.
  - Period = period·PRESCALE clk cycles.
  - Rising edges spaced exactly period·PRESCALE apart.
- `period_start` is asserted on the same edge `pwm_out` rises for a new period, including the first period after entry. It is asserted even when duty=0.
- Config change in PWM: new values govern the period starting after the current wrap. The old period always completes.
- `rst` mid-period: `pwm_out` drops to 0 asynchronously and the pending write is lost.
- All outputs registered; no combinational path from `cfg_*` to `pwm_out`.
- Counter arithmetic is unsigned WIDTH bits. Comparisons are unsigned; no overflow is possible since the counter is < period.

## Structure
- Package `pwm_pkg`: mode constants (`PWM_MODE_LOW`, `PWM_MODE_HIGH`, `PWM_MODE_PWM`, `PWM_MODE_PULSE`) and a state enum.
- Sub-module `pwm_prescaler`:
  - Parameter PRESCALE.
  - Ports: `clk`, `rst`, `clr`, `tick`.
  - Instantiated once.
- The rest (state machine, pending/active registers, tick counter, compare) lives in `pwm_gen`.

## Test plan
All scenarios use PRESCALE=4.
- Reset then idle: `pwm_out`=0, `busy`=0 for 1000 cycles with no writes.
- Write mode 1: `pwm_out`=1 one cycle after the strobe and stable for 1000 cycles. Then write mode 0: `pwm_out` returns to 0 one cycle later.
- Write mode 2, period=10, duty=3: high 12 clk, period 40 clk, duty 30 %, `period_start` once every 40 clk.
- Mid-period rewrite of the running PWM to period=10, duty=7 at counter=5: the current period keeps 12 clk high; the next period measures 28/40 = 70 %; `busy`=1 until the wrap.
- Write mode 3, duty=25: single 100-clk pulse, `busy` high for its duration, then `pwm_out`=0 for the following 1000 cycles. A second mode-3 write during the pulse yields a second 100-clk pulse after a 1-cycle low gap.
- Edge cases:
  - duty=0, period=10: constant 0 with `period_start` every 40 clk.
  - duty=12, period=10: constant 1.
  - period=0: constant 0, no `period_start`.
  - Assert `rst` mid-high: `pwm_out`=0 immediately.
